instr_player: RTL and testbench

Automated operator for the mini CPU front panel. Holds a small program of 18-bit instruction words and replays them into the CPU's switches/enviar interface with button-like timing: word stable, press, release, gap. Sits on the board in place of the physical switches and the enviar key, for bring-up and regression runs. Shares the CPU's clock domain.

---
 rtl/instr_player.sv | 210 +++++++++++++++++++++
 tb/tb_instr_player.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_player.sv
// ---------------------------------------------------------------------------
// instr_player
//
// Automated front-panel operator for the mini CPU. It holds a small program
// of 18-bit instruction words and replays them into the CPU's switches and
// enviar inputs with button-like timing. For each word it holds the word
// stable, then presses enviar, then releases it, then waits out a gap.
// It runs in the CPU's clock domain.
//
// Parameters:
//   ADDR_W        program address width
//   DEPTH         program words, expected to equal 2**ADDR_W
//   SETUP_CYCLES  cycles the word is stable before the press (>= 1)
//   PRESS_CYCLES  cycles enviar_n is held low (>= 3)
//   GAP_CYCLES    cycles released with the word still held (>= 2)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset (program memory is kept)
//   prog_we       program write strobe, honoured only while idle
//   prog_addr     program write address
//   prog_data     instruction word to write
//   prog_len      number of words to play, clamped to DEPTH
//   run           pulse: play the whole program from word 0
//   step          pulse: play the single word at pc
//   abort         pulse: stop playback, keep pc
//   switches_out  word presented to the CPU switches
//   enviar_n      active-low enviar key (0 = pressed)
//   busy          high whenever playback is in progress
//   done          level, set when the last word of the program completes
//   pc            index of the current or next word
// ---------------------------------------------------------------------------
module instr_player #(
    parameter int ADDR_W       = 4,
    parameter int DEPTH        = 16,
    parameter int SETUP_CYCLES = 2,
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [17:0]       prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              run,
    input  logic              step,
    input  logic              abort,
    output logic [17:0]       switches_out,
    output logic              enviar_n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {IDLE, SETUP, PRESS, GAP} state_t;
    typedef enum logic {MODE_RUN, MODE_STEP} mode_t;

    // One down-counter serves all three timed states, so it must be wide
    // enough for the longest of them.
    localparam int MAX_C = (SETUP_CYCLES > PRESS_CYCLES)
                         ? ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES)
                         : ((PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES);
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_LEN  = (ADDR_W + 1)'(DEPTH);

    logic [17:0] mem [DEPTH];

    state_t            state, state_n;
    mode_t             mode, mode_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] pc_n;
    logic              done_n;
    logic              load_word;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   last_idx;

    // Effective program length. A length of zero leaves last_idx at all
    // ones, which pc can never match, so a run that has its length zeroed
    // mid-flight simply keeps going instead of stopping on a bogus match.
    always_comb begin
        len_eff  = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
        last_idx = len_eff - 1'b1;
    end

    // Program memory. Writes are only accepted while idle so the word being
    // played can never change underneath the CPU. Reset does not clear it.
    always_ff @(posedge clk) begin
        if (!reset && prog_we && state == IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state logic. Each timed state loads the counter on entry and
    // leaves when it reaches zero. load_word marks every entry into SETUP,
    // which is the only moment switches_out is allowed to change.
    always_comb begin
        state_n   = state;
        mode_n    = mode;
        cnt_n     = cnt;
        pc_n      = pc;
        done_n    = done;
        load_word = 1'b0;

        case (state)
            IDLE: begin
                if (len_eff != '0) begin
                    if (run) begin
                        mode_n    = MODE_RUN;
                        pc_n      = '0;
                        done_n    = 1'b0;
                        state_n   = SETUP;
                        cnt_n     = SETUP_LOAD;
                        load_word = 1'b1;
                    end else if (step) begin
                        mode_n    = MODE_STEP;
                        done_n    = 1'b0;
                        state_n   = SETUP;
                        cnt_n     = SETUP_LOAD;
                        load_word = 1'b1;
                    end
                end
            end

            SETUP: begin
                if (cnt == '0) begin
                    state_n = PRESS;
                    cnt_n   = PRESS_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            PRESS: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            GAP: begin
                if (cnt == '0) begin
                    if ({1'b0, pc} == last_idx) begin
                        pc_n    = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        pc_n = pc + 1'b1;
                        if (mode == MODE_RUN) begin
                            state_n   = SETUP;
                            cnt_n     = SETUP_LOAD;
                            load_word = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort overrides whatever the timed states decided: pc and done
        // stay as they are so a later step resumes on the interrupted word.
        if (abort && state != IDLE) begin
            state_n   = IDLE;
            cnt_n     = cnt;
            pc_n      = pc;
            done_n    = done;
            load_word = 1'b0;
        end
    end

    // State and output registers. enviar_n and busy are derived from the
    // next state so they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mode         <= MODE_RUN;
            cnt          <= '0;
            pc           <= '0;
            switches_out <= '0;
            enviar_n     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state    <= state_n;
            mode     <= mode_n;
            cnt      <= cnt_n;
            pc       <= pc_n;
            done     <= done_n;
            enviar_n <= (state_n != PRESS);
            busy     <= (state_n != IDLE);
            if (load_word) begin
                switches_out <= mem[pc_n];
            end
        end
    end

endmodule

// File: tb/tb_instr_player.sv
// ---------------------------------------------------------------------------
// tb_instr_player
//
// Self-checking bench for instr_player. A shadow copy of the program and a
// timing model built from the word/press/gap arithmetic give the expected
// switches_out, enviar_n and busy on every cycle of playback, plus the
// expected pc and done once playback ends.
// ---------------------------------------------------------------------------
module tb_instr_player;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int S      = 2;
    localparam int P      = 4;
    localparam int G      = 4;
    localparam int T      = S + P + G;

    logic              clk;
    logic              reset;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [17:0]       prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              run;
    logic              step;
    logic              abort;
    logic [17:0]       switches_out;
    logic              enviar_n;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;

    int checks   = 0;
    int failures = 0;

    logic [17:0] model_mem [DEPTH];
    int          model_pc;
    logic        model_done;

    instr_player #(
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .SETUP_CYCLES (S),
        .PRESS_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .run          (run),
        .step         (step),
        .abort        (abort),
        .switches_out (switches_out),
        .enviar_n     (enviar_n),
        .busy         (busy),
        .done         (done),
        .pc           (pc)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word on the switches during cycle c (c = 1 is the cycle after accept).
    function automatic logic [17:0] exp_word(input int start, input int c);
        return model_mem[(start + (c - 1) / T) % DEPTH];
    endfunction

    // enviar_n during cycle c: low for offsets S .. S+P-1 inside each word.
    function automatic logic exp_enviar_n(input int c);
        int o;
        o = (c - 1) % T;
        return !(o >= S && o < S + P);
    endfunction

    // Writes one program word while the player is idle and mirrors it.
    task automatic write_word(input int a, input logic [17:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(a);
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
        model_mem[a] = d;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (switches_out !== 18'h0) begin
            failures++;
            $display("[TB] FAIL reset_switches got=%h want=0", switches_out);
        end
        checks++;
        if (enviar_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_enviar got=%b want=1", enviar_n);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy_done got=%b%b want=00", busy, done);
        end
        checks++;
        if (pc !== '0) begin
            failures++;
            $display("[TB] FAIL reset_pc got=%0d want=0", pc);
        end
        model_pc   = 0;
        model_done = 1'b0;
    endtask

    // Three-word program played with run, cycle by cycle.
    task automatic test_program_run();
        int low_cycles;
        int starts[$];
        logic prev_en;
        write_word(0, 18'h00005);
        write_word(1, 18'h0A004);
        write_word(2, 18'h3C080);
        prog_len = 5'd3;
        low_cycles = 0;
        prev_en = 1'b1;
        @(negedge clk);
        run = 1'b1;
        for (int c = 1; c <= 3 * T; c++) begin
            @(negedge clk);
            run = 1'b0;
            checks++;
            if (switches_out !== exp_word(0, c) || enviar_n !== exp_enviar_n(c) || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL run_trace c=%0d sw=%h want=%h en=%b want=%b busy=%b want=1",
                         c, switches_out, exp_word(0, c), enviar_n, exp_enviar_n(c), busy);
            end
            if (enviar_n === 1'b0) low_cycles++;
            if (prev_en === 1'b1 && enviar_n === 1'b0) starts.push_back(c);
            prev_en = enviar_n;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || pc !== '0) begin
            failures++;
            $display("[TB] FAIL run_end busy=%b done=%b pc=%0d want 0 1 0", busy, done, pc);
        end
        checks++;
        if (low_cycles != 3 * P || starts.size() != 3) begin
            failures++;
            $display("[TB] FAIL run_press_count low=%0d windows=%0d want %0d 3",
                     low_cycles, starts.size(), 3 * P);
        end else begin
            checks++;
            if (starts[1] - starts[0] != T || starts[2] - starts[1] != T) begin
                failures++;
                $display("[TB] FAIL run_press_spacing got=%0d,%0d want=%0d",
                         starts[1] - starts[0], starts[2] - starts[1], T);
            end
        end
        model_pc   = 0;
        model_done = 1'b1;
    endtask

    // Three steps through the same program: pc 1, 2, 0 and done only at the end.
    task automatic test_step();
        int presses;
        logic prev_en;
        for (int k = 0; k < 3; k++) begin
            presses = 0;
            prev_en = 1'b1;
            @(negedge clk);
            step = 1'b1;
            for (int c = 1; c <= T; c++) begin
                @(negedge clk);
                step = 1'b0;
                checks++;
                if (switches_out !== exp_word(model_pc, c) || enviar_n !== exp_enviar_n(c) || busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL step_trace k=%0d c=%0d sw=%h want=%h en=%b want=%b busy=%b",
                             k, c, switches_out, exp_word(model_pc, c), enviar_n, exp_enviar_n(c), busy);
                end
                if (prev_en === 1'b1 && enviar_n === 1'b0) presses++;
                prev_en = enviar_n;
            end
            model_pc   = (model_pc == 2) ? 0 : model_pc + 1;
            model_done = (model_pc == 0);
            @(negedge clk);
            checks++;
            if (pc !== ADDR_W'(model_pc) || done !== model_done || busy !== 1'b0 || presses != 1) begin
                failures++;
                $display("[TB] FAIL step_end k=%0d pc=%0d want=%0d done=%b want=%b busy=%b presses=%0d",
                         k, pc, model_pc, done, model_done, busy, presses);
            end
        end
    endtask

    // Abort on the second cycle of the first press, then resume with a step.
    task automatic test_abort();
        @(negedge clk);
        run = 1'b1;
        for (int c = 1; c <= S + 2; c++) begin
            @(negedge clk);
            run = 1'b0;
        end
        checks++;
        if (enviar_n !== 1'b0 || switches_out !== model_mem[0]) begin
            failures++;
            $display("[TB] FAIL abort_pre en=%b want=0 sw=%h want=%h", enviar_n, switches_out, model_mem[0]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (enviar_n !== 1'b1 || busy !== 1'b0 || pc !== '0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_post en=%b busy=%b pc=%0d done=%b want 1 0 0 0",
                     enviar_n, busy, pc, done);
        end
        model_pc   = 0;
        model_done = 1'b0;
        @(negedge clk);
        step = 1'b1;
        for (int c = 1; c <= T; c++) begin
            @(negedge clk);
            step = 1'b0;
            checks++;
            if (switches_out !== exp_word(0, c) || enviar_n !== exp_enviar_n(c)) begin
                failures++;
                $display("[TB] FAIL abort_resume c=%0d sw=%h want=%h en=%b want=%b",
                         c, switches_out, exp_word(0, c), enviar_n, exp_enviar_n(c));
            end
        end
        model_pc = 1;
        @(negedge clk);
        checks++;
        if (pc !== 4'd1 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_resume_end pc=%0d done=%b busy=%b want 1 0 0", pc, done, busy);
        end
    endtask

    // Zero length, clamped length and writes while busy.
    task automatic test_edges();
        prog_len = '0;
        @(negedge clk);
        run  = 1'b1;
        step = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        step = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || pc !== ADDR_W'(model_pc) || done !== model_done) begin
                failures++;
                $display("[TB] FAIL len0_idle busy=%b pc=%0d done=%b want 0 %0d %b",
                         busy, pc, done, model_pc, model_done);
            end
        end

        for (int a = 0; a < DEPTH; a++) write_word(a, 18'($urandom));
        prog_len = 5'd20;
        @(negedge clk);
        run = 1'b1;
        for (int c = 1; c <= DEPTH * T; c++) begin
            @(negedge clk);
            run = 1'b0;
            checks++;
            if (switches_out !== exp_word(0, c) || enviar_n !== exp_enviar_n(c) || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL clamp_trace c=%0d sw=%h want=%h en=%b want=%b busy=%b",
                         c, switches_out, exp_word(0, c), enviar_n, exp_enviar_n(c), busy);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || pc !== '0) begin
            failures++;
            $display("[TB] FAIL clamp_end busy=%b done=%b pc=%0d want 0 1 0", busy, done, pc);
        end

        // A write to word 1 during word 0 must not show up as word 1.
        prog_len = 5'd2;
        @(negedge clk);
        run = 1'b1;
        for (int c = 1; c <= 2 * T; c++) begin
            @(negedge clk);
            run = 1'b0;
            prog_we = 1'b0;
            checks++;
            if (switches_out !== exp_word(0, c) || enviar_n !== exp_enviar_n(c)) begin
                failures++;
                $display("[TB] FAIL busy_write_trace c=%0d sw=%h want=%h en=%b want=%b",
                         c, switches_out, exp_word(0, c), enviar_n, exp_enviar_n(c));
            end
            if (c == 5) begin
                prog_we   = 1'b1;
                prog_addr = 4'd1;
                prog_data = ~model_mem[1];
            end
        end
        @(negedge clk);
        model_pc   = 0;
        model_done = 1'b1;
    endtask

    // Reset during the gap of word 1, then replay from intact memory.
    task automatic test_reset_gap();
        prog_len = 5'd3;
        @(negedge clk);
        run = 1'b1;
        for (int c = 1; c <= T + S + P + 1; c++) begin
            @(negedge clk);
            run = 1'b0;
        end
        checks++;
        if (enviar_n !== 1'b1 || busy !== 1'b1 || switches_out !== model_mem[1]) begin
            failures++;
            $display("[TB] FAIL gap_pre en=%b busy=%b sw=%h want 1 1 %h",
                     enviar_n, busy, switches_out, model_mem[1]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (switches_out !== 18'h0 || enviar_n !== 1'b1 || pc !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gap_reset sw=%h en=%b pc=%0d done=%b busy=%b want 0 1 0 0 0",
                     switches_out, enviar_n, pc, done, busy);
        end
        @(negedge clk);
        run = 1'b1;
        for (int c = 1; c <= 3 * T; c++) begin
            @(negedge clk);
            run = 1'b0;
            checks++;
            if (switches_out !== exp_word(0, c) || enviar_n !== exp_enviar_n(c) || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL replay_trace c=%0d sw=%h want=%h en=%b want=%b busy=%b",
                         c, switches_out, exp_word(0, c), enviar_n, exp_enviar_n(c), busy);
            end
        end
        @(negedge clk);
        model_pc   = 0;
        model_done = 1'b1;
    endtask

    // Random programs, lengths and run/step choices.
    task automatic test_random();
        int len;
        int start;
        int words;
        bit use_run;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 4; k++) write_word($urandom_range(DEPTH - 1), 18'($urandom));
            len      = $urandom_range(DEPTH, 1);
            use_run  = $urandom_range(1);
            prog_len = 5'(len);
            start    = use_run ? 0 : model_pc;
            words    = use_run ? len : 1;
            @(negedge clk);
            if (use_run) run = 1'b1;
            else         step = 1'b1;
            for (int c = 1; c <= words * T; c++) begin
                @(negedge clk);
                run  = 1'b0;
                step = 1'b0;
                checks++;
                if (switches_out !== exp_word(start, c) || enviar_n !== exp_enviar_n(c) || busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL rand_trace it=%0d c=%0d sw=%h want=%h en=%b want=%b busy=%b",
                             it, c, switches_out, exp_word(start, c), enviar_n, exp_enviar_n(c), busy);
                end
            end
            if (use_run || model_pc == len - 1) begin
                model_pc   = 0;
                model_done = 1'b1;
            end else begin
                model_pc   = (model_pc + 1) % DEPTH;
                model_done = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || pc !== ADDR_W'(model_pc) || done !== model_done) begin
                failures++;
                $display("[TB] FAIL rand_end it=%0d busy=%b pc=%0d want=%0d done=%b want=%b",
                         it, busy, pc, model_pc, done, model_done);
            end
        end
    endtask

    // Test sequence.
    initial begin
        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        run       = 1'b0;
        step      = 1'b0;
        abort     = 1'b0;
        model_pc   = 0;
        model_done = 1'b0;

        test_reset();
        test_program_run();
        test_step();
        test_abort();
        test_edges();
        test_reset_gap();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
